// File: rtl/serial_adder_seq.sv
// serial_adder_seq: bit-serial adder reusing one full-adder cell over WIDTH bits, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, acc_q, acc_d, sum_q, sum_d, acc_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d, c_out_q, c_out_d;
  logic             s, cy, accept, last;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif
  always_comb begin
    s       = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    cy      = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));
    acc_nxt = {s, acc_q[WIDTH-1:1]};
    accept  = start && state_q != SHIFT;
    last    = cnt_q == CNT_W'(WIDTH - 1);
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (accept) begin
      state_d = SHIFT;
      a_sr_d  = a;
      b_sr_d  = b;
      carry_d = c_in;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      a_sr_d  = a_sr_q >> 1;
      b_sr_d  = b_sr_q >> 1;
      acc_d   = acc_nxt;
      carry_d = cy;
      cnt_d   = cnt_q + 1'b1;
      if (last) begin
        state_d = DONE;
        sum_d   = acc_nxt;
        c_out_d = cy;
`ifdef SERIAL_ADDER_OVF_EN
        // On the MSB step carry_q is the carry into the MSB and cy the carry out of it.
        ovf_d   = carry_q ^ cy;
`endif
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end
  assign busy  = state_q == SHIFT;
  assign done  = state_q == DONE;
  assign sum   = sum_q;
  assign c_out = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf   = ovf_q;
`endif
endmodule

// File: tb/tb_serial_adder_seq.sv
// tb_serial_adder_seq: directed table, multi-cycle corner sequences and a random run for serial_adder_seq.
module tb_serial_adder_seq;
  localparam int W = 8;
  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, c_in = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, c_out;
  logic [W-1:0] sum;
  int           checks = 0, failures = 0, pulses = 0;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif
  serial_adder_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c_in(c_in),
    .busy(busy), .done(done),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf),
`endif
    .sum(sum), .c_out(c_out)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (done) pulses++;
  typedef struct {
    logic [W-1:0] a, b;
    logic         ci;
    logic [W-1:0] s;
    logic         co;
  } vec_t;
  vec_t vecs[10];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Called at a negedge: presents the operands for one edge, then scrambles them.
  task automatic accept(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
    start = 1'b1; a = xa; b = xb; c_in = xc;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
  endtask
  task automatic wait_done(output int lat, output int bc);
    lat = 1;
    bc = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask
  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc, output int lat, output int bc);
    @(negedge clk);
    accept(xa, xb, xc);
    wait_done(lat, bc);
  endtask
  initial begin
    int lat, bc, p0;
    logic [W:0] m;
    logic [W-1:0] ra, rb;
    logic rc;
    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[8] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs[9] = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1};
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(c_out), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].ci, lat, bc);
      chk($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].s));
      chk($sformatf("vec%0d_cout", i), 32'(c_out), 32'(vecs[i].co));
      chk($sformatf("vec%0d_latency", i), 32'(lat), W + 1);
      chk($sformatf("vec%0d_busy_cycles", i), 32'(bc), W);
      @(negedge clk);
      chk($sformatf("vec%0d_done_one_cycle", i), 32'(done), 0);
    end
    // start during SHIFT is ignored; start in the DONE cycle is taken with no bubble
    @(negedge clk);
    accept(8'h0F, 8'h01, 1'b0);
    @(negedge clk);
    start = 1'b1; a = 8'h55; b = 8'h55;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    chk("midstart_sum", 32'(sum), 32'h10);
    chk("midstart_cout", 32'(c_out), 0);
    accept(8'h55, 8'h55, 1'b0);
    wait_done(lat, bc);
    chk("b2b_sum", 32'(sum), 32'hAA);
    chk("b2b_cout", 32'(c_out), 0);
    chk("b2b_latency", 32'(lat), W + 1);
    // asynchronous reset in the middle of an operation
    @(negedge clk);
    accept(8'h0F, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_sum", 32'(sum), 0);
    chk("midrst_cout", 32'(c_out), 0);
    p0 = pulses;
    repeat (12) @(negedge clk);
    chk("midrst_no_pulse", 32'(pulses), 32'(p0));
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("postrst_no_pulse", 32'(pulses), 32'(p0));
    do_op(8'h01, 8'h02, 1'b0, lat, bc);
    chk("postrst_sum", 32'(sum), 32'h03);
    chk("postrst_latency", 32'(lat), W + 1);
`ifdef SERIAL_ADDER_OVF_EN
    do_op(8'h7F, 8'h01, 1'b0, lat, bc);
    chk("ovf1_sum", 32'(sum), 32'h80);
    chk("ovf1_ovf", 32'(ovf), 1);
    do_op(8'hFF, 8'h01, 1'b0, lat, bc);
    chk("ovf2_ovf", 32'(ovf), 0);
    chk("ovf2_cout", 32'(c_out), 1);
    do_op(8'h80, 8'h80, 1'b0, lat, bc);
    chk("ovf3_sum", 32'(sum), 32'h00);
    chk("ovf3_cout", 32'(c_out), 1);
    chk("ovf3_ovf", 32'(ovf), 1);
`endif
    @(negedge clk);
    p0 = pulses;
    for (int i = 0; i < 500; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      m = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      do_op(ra, rb, rc, lat, bc);
      chk($sformatf("rnd%0d_sum", i), 32'(sum), 32'(m[W-1:0]));
      chk($sformatf("rnd%0d_cout", i), 32'(c_out), 32'(m[W]));
      chk($sformatf("rnd%0d_latency", i), 32'(lat), W + 1);
`ifdef SERIAL_ADDER_OVF_EN
      chk($sformatf("rnd%0d_ovf", i), 32'(ovf), 32'((ra[W-1] == rb[W-1]) && (m[W-1] != ra[W-1])));
`endif
    end
    @(negedge clk);
    chk("rnd_pulse_count", 32'(pulses - p0), 500);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
